pe_feeder: RTL and testbench

- Operand feeder at the input edge of the linear PE array.
- Collects a tile of K activation and weight row-vectors from upstream over a valid/ready handshake into a local buffer.
- Streams the tile diagonally skewed: lane i is delayed i cycles, with zero padding, into the array's per-lane a/w inputs.
- Drives the array's fire strobe and pulses tile_done at the end of each tile.

---
 rtl/pe_feeder.sv | 144 ++++++++++++++
 tb/tb_pe_feeder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Operand feeder for the linear PE array: buffers a tile of activation/weight rows,
// then streams it diagonally skewed (lane i delayed i steps, zero padded) into the array.
module pe_feeder #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [N*DW-1:0] s_a,
    input  logic [N*DW-1:0] s_w,
    input  logic            s_last,
    input  logic            hold,
    output logic [N*DW-1:0] out_a,
    output logic [N*DW-1:0] out_w,
    output logic            fire,
    output logic            tile_done,
    output logic            ovf
);
    localparam int LW = N * DW;
    localparam int KW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(DEPTH + N);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d, k_inc;
    logic [TW-1:0]   t_q, t_d, t_end;
    logic [LW-1:0]   out_a_q, out_a_d, out_w_q, out_w_d;
    logic [LW-1:0]   step_a, step_w;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic            run_q, run_d;
    logic            accept, wr_en;
    logic [AW-1:0]   wr_idx;
    logic [LW-1:0]   mem_a [DEPTH];
    logic [LW-1:0]   mem_w [DEPTH];

    // Upstream valid/ready: a row transfers on a rising edge where s_valid and s_ready are both high.
    assign s_ready   = run_q && (state_q == IDLE || state_q == LOAD);
    assign accept    = s_valid && s_ready;
    assign k_inc     = (state_q == IDLE) ? KW'(1) : k_q + KW'(1);
    assign t_end     = TW'(k_q) + TW'(N - 1);
    assign out_a     = out_a_q;
    assign out_w     = out_w_q;
    assign fire      = (state_q == STREAM) && valid_q && !hold;
    assign tile_done = (state_q == DONE);
    assign ovf       = ovf_q;
    assign run_d     = 1'b1;

    // Step t: lane i carries row t-i when that row exists, otherwise zero.
    always_comb begin
        step_a = '0;
        step_w = '0;
        for (int i = 0; i < N; i++) begin
            if (t_q >= TW'(i) && (t_q - TW'(i)) < TW'(k_q)) begin
                step_a[i*DW +: DW] = mem_a[AW'(t_q - TW'(i))][i*DW +: DW];
                step_w[i*DW +: DW] = mem_w[AW'(t_q - TW'(i))][i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        out_a_d = out_a_q;
        out_w_d = out_w_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = (state_q == IDLE) ? '0 : AW'(k_q);
                    k_d    = k_inc;
                    if (s_last || k_inc == KW'(DEPTH)) begin
                        state_d = STREAM;
                        t_d     = '0;
                        if (!s_last) ovf_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            STREAM: begin
                if (!hold) begin
                    // t_end is the extra flush step that retires the last presented step.
                    if (t_q == t_end) begin
                        out_a_d = '0;
                        out_w_d = '0;
                        valid_d = 1'b0;
                        t_d     = '0;
                        state_d = DONE;
                    end else begin
                        out_a_d = step_a;
                        out_w_d = step_w;
                        valid_d = 1'b1;
                        t_d     = t_q + TW'(1);
                    end
                end
            end
            DONE: begin
                k_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            k_q     <= '0;
            t_q     <= '0;
            out_a_q <= '0;
            out_w_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
            out_a_q <= out_a_d;
            out_w_q <= out_w_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            run_q   <= run_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a[wr_idx] <= s_a;
            mem_w[wr_idx] <= s_w;
        end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: directed tiles with literal expectations plus randomized tiles
// checked every cycle against a skew model built from the row buffer contents.
module tb_pe_feeder;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = N * DW;
    localparam int EW    = 1 + 2 * LW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [LW-1:0] s_a = '0;
    logic [LW-1:0] s_w = '0;
    logic          s_last = 1'b0;
    logic          hold = 1'b0;
    logic [LW-1:0] out_a, out_w;
    logic          fire, tile_done, ovf;

    pe_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_w(s_w), .s_last(s_last), .hold(hold),
        .out_a(out_a), .out_w(out_w), .fire(fire), .tile_done(tile_done), .ovf(ovf)
    );

    // Clock and cycle index (value seen at a negedge names the current cycle)
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [LW-1:0] tile_a[DEPTH];
    logic [LW-1:0] tile_w[DEPTH];
    bit            ovf_m = 0, pend_done = 0, chk_en = 0, hold_rand = 0;
    int            done_cnt = 0;
    int            done_cyc[$];
    int            cap_cyc[$];
    logic [LW-1:0] cap_a[$], cap_w[$];
    int            first_acc_cyc, last_acc_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: step t, lane i = row[t-i] lane i when 0 <= t-i < k, else 0; k+N-1 steps.
    task automatic push_model(input int k, input bit closed_by_last);
        logic [LW-1:0] a, w;
        for (int t = 0; t < k + N - 1; t++) begin
            a = '0;
            w = '0;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < k) begin
                    a[i*DW +: DW] = tile_a[t-i][i*DW +: DW];
                    w[i*DW +: DW] = tile_w[t-i][i*DW +: DW];
                end
            end
            exp_q.push_back({(t == k + N - 2), a, w});
        end
        if (!closed_by_last) ovf_m = 1;
    endtask

    // Driver: offers rows 0..k-1 of tile_a/tile_w; s_valid is left high afterwards.
    task automatic send_tile(input int k, input bit use_last, input bit gaps);
        bit acc;
        int waited;
        for (int r = 0; r < k; r++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_a     = tile_a[r];
            s_w     = tile_w[r];
            s_last  = use_last && (r == k - 1);
            acc     = 0;
            waited  = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_ready;
                if (acc && r == 0) first_acc_cyc = cyc;
                if (acc) last_acc_cyc = cyc;
                @(posedge clk); #1;
                waited++;
                if (!acc && waited > 300) begin
                    chk("beat_accept_timeout", 64'(s_ready), 64'd1);
                    return;
                end
            end
        end
        push_model(k, use_last);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_w     = '0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target) begin
            @(posedge clk);
            n++;
            if (n > 500) begin
                chk("tile_done_timeout", 64'(done_cnt), 64'(target));
                return;
            end
        end
        #1;
    endtask

    task automatic clear_caps();
        cap_cyc.delete();
        cap_a.delete();
        cap_w.delete();
        done_cyc.delete();
    endtask

    task automatic set_seq_tile(input int k);
        for (int r = 0; r < k; r++) begin
            for (int i = 0; i < N; i++) begin
                tile_a[r][i*DW +: DW] = DW'(4 * r + i + 1);
                tile_w[r][i*DW +: DW] = DW'(4 * r + i + 101);
            end
        end
    endtask

    task automatic set_rand_tile(input int k);
        for (int r = 0; r < k; r++) begin
            tile_a[r] = LW'($urandom);
            tile_w[r] = LW'($urandom);
        end
    endtask

    // Compare process: every cycle out of reset
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (chk_en && rstn) begin
            chk("tile_done", 64'(tile_done), 64'(pend_done));
            if (tile_done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            pend_done = 0;
            chk("ovf", 64'(ovf), 64'(ovf_m));
            if (exp_q.size() != 0 || tile_done) chk("s_ready_low_busy", 64'(s_ready), 64'd0);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    chk("fire_unexpected", 64'(fire), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_a", 64'(out_a), 64'(e[2*LW-1:LW]));
                    chk("out_w", 64'(out_w), 64'(e[LW-1:0]));
                    pend_done = e[EW-1];
                    cap_cyc.push_back(cyc);
                    cap_a.push_back(out_a);
                    cap_w.push_back(out_w);
                end
            end
        end
    end

    // Random stall source
    always @(posedge clk) begin
        #1;
        if (hold_rand) hold = ($urandom_range(0, 3) == 0);
    end

    logic [LW-1:0] lit_a[6] = '{32'h00000001, 32'h00000205, 32'h00030609,
                               32'h04070A00, 32'h080B0000, 32'h0C000000};
    logic [LW-1:0] lit_w[6] = '{32'h00000065, 32'h00006669, 32'h00676A6D,
                               32'h686B6E00, 32'h6C6F0000, 32'h70000000};
    logic [LW-1:0] k1_lit[4] = '{32'h00000007, 32'h00000700, 32'h00070000, 32'h07000000};

    initial begin
        int c, base, k;
        bit ul;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_a", 64'(out_a), 64'd0);
        chk("rst_out_w", 64'(out_w), 64'd0);
        chk("rst_fire", 64'(fire), 64'd0);
        chk("rst_tile_done", 64'(tile_done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        rstn   = 1'b1;
        chk_en = 1;

        // Directed K=3 tile, no stall
        clear_caps();
        set_seq_tile(3);
        send_tile(3, 1, 0);
        idle();
        wait_done(1);
        chk("t1_fire_count", 64'(cap_a.size()), 64'd6);
        if (cap_a.size() == 6) begin
            chk("t1_first_fire_latency", 64'(cap_cyc[0] - last_acc_cyc), 64'd2);
            for (int j = 0; j < 6; j++) begin
                chk("t1_lit_a", 64'(cap_a[j]), 64'(lit_a[j]));
                chk("t1_lit_w", 64'(cap_w[j]), 64'(lit_w[j]));
                chk("t1_fire_consecutive", 64'(cap_cyc[j] - cap_cyc[0]), 64'(j));
            end
            if (done_cyc.size() > 0) chk("t1_done_cycle", 64'(done_cyc[0] - cap_cyc[0]), 64'd6);
        end
        chk("t1_ovf", 64'(ovf), 64'd0);

        // Same tile with a 2-cycle stall on step 2
        clear_caps();
        set_seq_tile(3);
        send_tile(3, 1, 0);
        idle();
        c = last_acc_cyc;
        while (cyc != c + 4) begin @(posedge clk); #1; end
        hold = 1'b1;
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            chk("hold_fire_low", 64'(fire), 64'd0);
            chk("hold_out_a_frozen", 64'(out_a), 64'(lit_a[2]));
            @(posedge clk); #1;
        end
        hold = 1'b0;
        wait_done(2);
        chk("t2_fire_count", 64'(cap_a.size()), 64'd6);
        if (cap_a.size() == 6) begin
            chk("t2_span", 64'(cap_cyc[5] - cap_cyc[0]), 64'd7);
            for (int j = 0; j < 6; j++) chk("t2_lit_a", 64'(cap_a[j]), 64'(lit_a[j]));
        end

        // Single-row tile
        clear_caps();
        tile_a[0] = 32'h07070707;
        tile_w[0] = 32'h07070707;
        send_tile(1, 1, 0);
        idle();
        wait_done(3);
        chk("k1_fire_count", 64'(cap_a.size()), 64'd4);
        if (cap_a.size() == 4)
            for (int j = 0; j < 4; j++) chk("k1_lit_a", 64'(cap_a[j]), 64'(k1_lit[j]));

        // Two tiles with s_valid held high throughout
        clear_caps();
        base = done_cnt;
        set_rand_tile(2);
        send_tile(2, 1, 0);
        set_rand_tile(3);
        send_tile(3, 1, 0);
        idle();
        wait_done(base + 2);
        chk("b2b_done_pulses", 64'(done_cyc.size()), 64'd2);
        if (done_cyc.size() >= 1)
            chk("b2b_tile2_first_accept", 64'(first_acc_cyc), 64'(done_cyc[0] + 1));

        // Overflow: DEPTH rows without s_last
        clear_caps();
        base = done_cnt;
        set_rand_tile(DEPTH);
        send_tile(DEPTH, 0, 1);
        @(negedge clk);
        chk("ovf_s_ready_drop", 64'(s_ready), 64'd0);
        chk("ovf_set", 64'(ovf), 64'd1);
        @(posedge clk); #1;
        idle();
        wait_done(base + 1);
        chk("ovf_steps", 64'(cap_a.size()), 64'd11);
        chk("ovf_done_once", 64'(done_cyc.size()), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // Reset during step 3 of a tile
        @(posedge clk); #1;
        set_rand_tile(3);
        send_tile(3, 1, 0);
        idle();
        c = last_acc_cyc;
        while (cyc != c + 5) begin @(posedge clk); #1; end
        rstn = 1'b0;
        #1;
        chk("mid_rst_fire", 64'(fire), 64'd0);
        chk("mid_rst_out_a", 64'(out_a), 64'd0);
        chk("mid_rst_out_w", 64'(out_w), 64'd0);
        chk("mid_rst_tile_done", 64'(tile_done), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        exp_q.delete();
        pend_done = 0;
        ovf_m     = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        clear_caps();
        base = done_cnt;
        set_rand_tile(2);
        send_tile(2, 1, 0);
        idle();
        wait_done(base + 1);
        chk("post_rst_steps", 64'(cap_a.size()), 64'd5);

        // Randomized tiles with random stalls and valid gaps
        base      = done_cnt;
        hold_rand = 1;
        for (int n = 0; n < 25; n++) begin
            k  = $urandom_range(1, DEPTH);
            ul = (k < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            set_rand_tile(k);
            send_tile(k, ul, 1'($urandom_range(0, 1)));
        end
        idle();
        wait_done(base + 25);
        hold_rand = 0;
        @(posedge clk); #1;
        hold = 1'b0;
        repeat (3) @(posedge clk);
        chk("rand_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
